// File: rtl/rr_stream_mux_4.sv
// Four-input round-robin stream selector feeding a 4:1 data mux stage.
// One registered output beat per accepted transfer, carrying its data and select.
module rr_stream_mux_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] grant_data;
  logic [1:0]   grant;
  logic [1:0]   scan_idx;
  logic         grant_found;
  logic         can_accept;
  logic         xfer;

  assign can_accept = (state_q == EMPTY) || out_ready;
  assign xfer       = grant_found && can_accept;

  // Scan starting at ptr so the most recently served input has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant       = 2'd0;
    scan_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!grant_found && in_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant       = scan_idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (xfer && !rst) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  // A new beat loads even while the old one drains, giving one beat per cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = grant_data;
      sel_d   = grant;
      ptr_d   = grant + 2'd1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_stream_mux_4.sv
// Directed bench for rr_stream_mux_4: stimulus pushes expected beats into a
// queue, and a monitor pops and compares whenever an output beat is consumed.
module tb_rr_stream_mux_4;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } beat_t;

  beat_t exp_q[$];
  int    num_checks = 0;
  int    num_fails  = 0;

  rr_stream_mux_4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_valid  = valid;
    out_ready = ready;
    in_data0  = d0;
    in_data1  = d1;
    in_data2  = d2;
    in_data3  = d3;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectBeat(input logic [W-1:0] data, input logic [1:0] sel);
    beat_t b;
    b.data = data;
    b.sel  = sel;
    exp_q.push_back(b);
  endtask

  // Beats are compared at the falling edge before the edge that consumes them.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", {28'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        checkOutput("beat_data", {28'd0, out_data}, {28'd0, b.data});
        checkOutput("beat_sel", {30'd0, out_sel}, {30'd0, b.sel});
      end
    end
  end

  initial begin
    logic [3:0] rr_ready [0:6];
    logic [3:0] rr_data  [0:6];
    rr_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    rr_data  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3};

    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    nextCycle();
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {28'd0, out_data}, 32'd0);
    checkOutput("reset_out_sel", {30'd0, out_sel}, 32'd0);
    checkOutput("reset_in_ready", {28'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Single requester on input 2.
    applyStimulus(4'b0100, 1'b1, 4'h0, 4'h0, 4'hA, 4'h0);
    #1;
    checkOutput("single_in_ready", {28'd0, in_ready}, 32'h4);
    expectBeat(4'hA, 2'd2);
    nextCycle();
    applyStimulus(4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("single_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_out_data", {28'd0, out_data}, 32'hA);
    checkOutput("single_out_sel", {30'd0, out_sel}, 32'd2);

    // Drain without refill.
    nextCycle();
    checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_out_data_hold", {28'd0, out_data}, 32'hA);
    checkOutput("drain_out_sel_hold", {30'd0, out_sel}, 32'd2);

    // Skip and wrap: ptr is 3.
    applyStimulus(4'b0011, 1'b1, 4'h5, 4'h6, 4'h0, 4'h0);
    #1;
    checkOutput("wrap_grant0", {28'd0, in_ready}, 32'h1);
    expectBeat(4'h5, 2'd0);
    nextCycle();
    checkOutput("wrap_grant1", {28'd0, in_ready}, 32'h2);
    expectBeat(4'h6, 2'd1);
    nextCycle();
    checkOutput("wrap_grant0_again", {28'd0, in_ready}, 32'h1);
    expectBeat(4'h5, 2'd0);
    nextCycle();
    applyStimulus(4'b0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    nextCycle();
    checkOutput("wrap_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation: ptr is 1, load a beat from input 2 and hold it.
    applyStimulus(4'b0100, 1'b0, 4'h0, 4'h0, 4'h7, 4'h0);
    #1;
    checkOutput("midrst_in_ready", {28'd0, in_ready}, 32'h4);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    checkOutput("midrst_loaded", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", {28'd0, out_data}, 32'd0);
    checkOutput("midrst_out_sel", {30'd0, out_sel}, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Round robin with all inputs valid; first grant after reset is input 0.
    applyStimulus(4'b1111, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int k = 0; k < 7; k++) begin
      #1;
      checkOutput("rr_in_ready", {28'd0, in_ready}, {28'd0, rr_ready[k]});
      expectBeat(rr_data[k], rr_ready[k][0] ? 2'd0 : rr_ready[k][1] ? 2'd1 :
                             rr_ready[k][2] ? 2'd2 : 2'd3);
      nextCycle();
      checkOutput("rr_no_bubble", {31'd0, out_valid}, 32'd1);
    end

    // Backpressure: output holds data 3 from input 2; ptr is 3.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_in_ready", {28'd0, in_ready}, 32'd0);
      checkOutput("bp_out_data", {28'd0, out_data}, 32'd3);
      checkOutput("bp_out_sel", {30'd0, out_sel}, 32'd2);
      nextCycle();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_resume_grant", {28'd0, in_ready}, 32'h8);
    expectBeat(4'd4, 2'd3);
    nextCycle();
    applyStimulus(4'b0000, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    nextCycle();
    checkOutput("final_drain_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("final_drain_data", {28'd0, out_data}, 32'd4);
    in_valid = 4'b1111;
    #1;
    checkOutput("final_ptr_hold", {28'd0, in_ready}, 32'h1);
    in_valid = 4'b0000;

    nextCycle();
    nextCycle();
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux_4.md
Name: rr_stream_mux_4

Overview:
Four-input round-robin stream selector that sits directly upstream of the 4:1 data mux stage. It arbitrates four valid/ready producers and generates the 2-bit select for the chosen input. It presents one registered output beat per accepted transfer, with the data and the select that produced it. Starvation-free: every requesting input is served within 4 grants.

Parameters:
W, 4, data width of each input and of the output.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  4  in_valid[i]: input i offers a beat.
in_data0  input  W  data of input 0.
in_data1  input  W  data of input 1.
in_data2  input  W  data of input 2.
in_data3  input  W  data of input 3.
in_ready  output  4  in_ready[i]: beat on input i is accepted this cycle (one-hot or zero).
out_valid  output  1  output register holds a beat.
out_data  output  W  registered data of the granted input.
out_sel  output  2  registered index of the granted input (the mux select).
out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready=0 while rst=1.
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- can_accept = !out_valid || out_ready.
- Grant (combinational): scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). g = first index with in_valid set. If none is set, there is no grant.
- in_ready[g] = can_accept; all other in_ready bits = 0. in_ready may depend combinationally on in_valid and out_ready. No combinational path from in_data to any output.
- Transfer on input g = in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data_g, out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod 4, wrapping 3 -> 0.
- Output drained (out_valid && out_ready) with no input transfer: out_valid <= 0. out_data and out_sel hold their last values.
- Drain and accept in the same cycle: the new beat loads and out_valid stays 1. This gives 1 beat/cycle sustained throughput.
- FULL and out_ready=0: out_valid, out_data and out_sel hold stable. All in_ready=0. ptr holds.
- No transfer: ptr holds. ptr changes only on a transfer.
- Latency: 1 cycle from input transfer edge to out_valid/out_data visible.
- Producers may drop in_valid without a transfer. The arbiter must not lock onto any input.
- Reset mid-operation: any in-flight output beat is discarded (out_valid=0 immediately). ptr returns to 0.
- Fairness: with all 4 inputs valid continuously and out_ready=1, out_sel sequences 0,1,2,3,0,...

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 -> out_valid, out_data and out_sel drop to 0 asynchronously, before the next clk edge. After release, the first grant with all inputs valid is input 0.
- Single requester: in_valid=4'b0100, in_data2=4'hA, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=4'hA, out_sel=2. ptr=3.
- Round robin: in_valid=4'b1111, data0..3=1,2,3,4, out_ready=1 held -> out_data sequence 1,2,3,4,1 on consecutive cycles. out_valid stays 1 throughout, with no bubbles.
- Backpressure: output FULL with out_data=4'h3, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0 throughout and out_data/out_sel stable. The first cycle out_ready=1 accepts the next input in rotation.
- Skip and wrap: ptr=3, in_valid=4'b0011 -> input 0 granted, then ptr=1. Next cycle input 1 is granted, then ptr=2 and input 0 is granted.
- Drain without refill: FULL, out_ready=1, in_valid=0 -> out_valid=0 next cycle. out_data keeps its last value and ptr is unchanged.
